// File: rtl/fwd_sel_gen_pkg.sv
// Shared CPU constants: forwarding select codes, MD FSM states and the
// destination-shadow record used by the hazard/forwarding logic.
package fwd_sel_gen_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2,
    FWD_WB1   = 2'd3
  } fwd_sel_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_RSVD = 2'd3
  } md_op_t;

  // Shadow index 0 = EX, 1 = MEM, 2 = WB, 3 = WB+1
  localparam int NUM_SHADOW = 4;

  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
    logic       is_load;
  } shadow_t;

  function automatic logic src_hit(input shadow_t s, input logic [4:0] src, input logic used);
    return s.valid && used && (src != 5'd0) && (s.addr == src);
  endfunction

  // Walk from the oldest stage to the youngest so the nearest producer wins;
  // a WB+1 producer has already reached the register file.
  function automatic fwd_sel_t sel_from_match(input logic [NUM_SHADOW-1:0] m);
    fwd_sel_t sel;
    sel = FWD_RF;
    for (int i = NUM_SHADOW - 1; i >= 0; i--) begin
      if (m[i]) begin
        case (i)
          0:       sel = FWD_EXMEM;
          1:       sel = FWD_MEMWB;
          2:       sel = FWD_WB1;
          default: sel = FWD_RF;
        endcase
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_sel_gen_if.sv
// ID-stage hazard inputs and forwarding/stall outputs of fwd_sel_gen.
interface fwd_sel_gen_if;
  import fwd_sel_gen_pkg::*;

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_rs_used;
  logic       id_rt_used;
  logic       id_we;
  logic [4:0] id_wa;
  logic       id_is_load;
  logic [1:0] id_md_start;
  logic       id_hilo_rd;
  logic       flush;
  fwd_sel_t   fwd_a_sel;
  fwd_sel_t   fwd_b_sel;
  logic       stall;
  logic       md_busy;

  modport master (
    output id_rs, id_rt, id_rs_used, id_rt_used, id_we, id_wa, id_is_load,
           id_md_start, id_hilo_rd, flush,
    input  fwd_a_sel, fwd_b_sel, stall, md_busy
  );

  modport slave (
    input  id_rs, id_rt, id_rs_used, id_rt_used, id_we, id_wa, id_is_load,
           id_md_start, id_hilo_rd, flush,
    output fwd_a_sel, fwd_b_sel, stall, md_busy
  );

endinterface

// File: rtl/fwd_sel_gen_md_busy_fsm.sv
// Multiply/divide occupancy tracker: IDLE/BUSY/DONE with a latency down-counter.
module md_busy_fsm
  import fwd_sel_gen_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_ok,
  input  logic [1:0] md_op,
  output logic       md_busy
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  md_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             start;
  logic [CNT_W-1:0] load_val;

  assign start    = start_ok && ((md_op == MD_MULT) || (md_op == MD_DIV));
  assign load_val = (md_op == MD_DIV) ? DIV_LOAD : MULT_LOAD;
  assign md_busy  = (state_reg == MD_BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= MD_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      MD_IDLE, MD_DONE: begin
        if (start) begin
          state_next = MD_BUSY;
          cnt_next   = load_val;
        end else begin
          state_next = MD_IDLE;
        end
      end
      MD_BUSY: begin
        if (cnt_reg == '0) begin
          state_next = MD_DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = MD_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/fwd_sel_gen.sv
// ID-stage forwarding select generator: destination shadows for EX..WB+1,
// registered operand selects, load-use and multiply/divide stalls.
module fwd_sel_gen
  import fwd_sel_gen_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic         clk,
  input logic         rst_n,
  fwd_sel_gen_if.slave bus
);

  shadow_t               shadow_reg [NUM_SHADOW];
  shadow_t               id_dest;
  logic [NUM_SHADOW-1:0] match_a;
  logic [NUM_SHADOW-1:0] match_b;
  logic                  load_use;
  logic                  md_stall;
  logic                  stall;
  logic                  bubble;
  logic                  md_busy;
  fwd_sel_t              sel_a_reg, sel_b_reg;

  assign id_dest = '{valid: bus.id_we, addr: bus.id_wa, is_load: bus.id_is_load};

  for (genvar gi = 0; gi < NUM_SHADOW; gi++) begin : g_match
    assign match_a[gi] = src_hit(shadow_reg[gi], bus.id_rs, bus.id_rs_used);
    assign match_b[gi] = src_hit(shadow_reg[gi], bus.id_rt, bus.id_rt_used);
  end

  // A load still in EX has no result to forward yet; hold ID for one slot.
  assign load_use = shadow_reg[0].is_load && (match_a[0] || match_b[0]);
  assign md_stall = md_busy && (bus.id_hilo_rd || (bus.id_md_start != 2'b00));
  assign stall    = load_use || md_stall;
  assign bubble   = stall || bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SHADOW; i++) begin
        shadow_reg[i] <= '0;
      end
      sel_a_reg <= FWD_RF;
      sel_b_reg <= FWD_RF;
    end else begin
      for (int i = NUM_SHADOW - 1; i > 0; i--) begin
        shadow_reg[i] <= shadow_reg[i-1];
      end
      shadow_reg[0] <= bubble ? '0 : id_dest;
      sel_a_reg     <= bubble ? FWD_RF : sel_from_match(match_a);
      sel_b_reg     <= bubble ? FWD_RF : sel_from_match(match_b);
    end
  end

  md_busy_fsm #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_ok (!bubble),
    .md_op    (bus.id_md_start),
    .md_busy  (md_busy)
  );

  assign bus.fwd_a_sel = sel_a_reg;
  assign bus.fwd_b_sel = sel_b_reg;
  assign bus.stall     = stall;
  assign bus.md_busy   = md_busy;

endmodule

// File: tb/tb_fwd_sel_gen.sv
// Directed bench for fwd_sel_gen: per-cycle comparison against a pipeline
// history model plus hand-computed literal expectations for each scenario.
module tb_fwd_sel_gen;
  import fwd_sel_gen_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  fwd_sel_gen_if bus();

  fwd_sel_gen #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Model: destination register of the instruction in EX, MEM, WB, WB+1
  // (-1 = nothing written), load flag of each, and remaining MD busy cycles.
  int m_dst [4];
  bit m_ld  [4];
  int m_rem;
  int m_sel_a;
  int m_sel_b;

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_dst[k] = -1;
      m_ld[k]  = 1'b0;
    end
    m_rem   = 0;
    m_sel_a = 0;
    m_sel_b = 0;
  endtask

  function automatic int src_sel(input int src, input bit used);
    if (!used || src == 0) return 0;
    for (int k = 0; k < 3; k++) begin
      if (m_dst[k] == src) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit load_hz(input int src, input bit used);
    return used && src != 0 && m_dst[0] == src && m_ld[0];
  endfunction

  initial begin : compare_proc
    bit exp_stall;
    bit bub;
    int na;
    int nb;
    model_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_stall", bus.stall, 8'd0);
        check("rst_md_busy", bus.md_busy, 8'd0);
        check("rst_sel_a", bus.fwd_a_sel, 8'd0);
        check("rst_sel_b", bus.fwd_b_sel, 8'd0);
        model_clear();
      end else begin
        exp_stall = load_hz(int'(bus.id_rs), bus.id_rs_used) ||
                    load_hz(int'(bus.id_rt), bus.id_rt_used) ||
                    (m_rem > 0 && (bus.id_hilo_rd || bus.id_md_start != 2'b00));
        check("cyc_stall", bus.stall, 8'(exp_stall));
        check("cyc_md_busy", bus.md_busy, 8'(m_rem > 0));
        check("cyc_sel_a", bus.fwd_a_sel, 8'(m_sel_a));
        check("cyc_sel_b", bus.fwd_b_sel, 8'(m_sel_b));
        bub = exp_stall || bus.flush;
        na  = bub ? 0 : src_sel(int'(bus.id_rs), bus.id_rs_used);
        nb  = bub ? 0 : src_sel(int'(bus.id_rt), bus.id_rt_used);
        for (int k = 3; k > 0; k--) begin
          m_dst[k] = m_dst[k-1];
          m_ld[k]  = m_ld[k-1];
        end
        m_dst[0] = (!bub && bus.id_we) ? int'(bus.id_wa) : -1;
        m_ld[0]  = !bub && bus.id_we && bus.id_is_load;
        if (m_rem > 0) m_rem--;
        else if (!bub && bus.id_md_start == 2'b01) m_rem = MULT_LAT;
        else if (!bub && bus.id_md_start == 2'b10) m_rem = DIV_LAT;
        m_sel_a = na;
        m_sel_b = nb;
      end
    end
  end

  task automatic issue(input string tag, input int rs, input bit ru, input int rt, input bit tu,
                       input bit we, input int wa, input bit ld, input int md, input bit hilo,
                       input bit fl);
    bus.id_rs       = 5'(rs);
    bus.id_rs_used  = ru;
    bus.id_rt       = 5'(rt);
    bus.id_rt_used  = tu;
    bus.id_we       = we;
    bus.id_wa       = 5'(wa);
    bus.id_is_load  = ld;
    bus.id_md_start = 2'(md);
    bus.id_hilo_rd  = hilo;
    bus.flush       = fl;
    $display("t=%0t issue %-12s rs=%0d/%0d rt=%0d/%0d we=%0d wa=%0d ld=%0d md=%0d hilo=%0d flush=%0d",
             $time, tag, rs, ru, rt, tu, we, wa, ld, md, hilo, fl);
  endtask

  task automatic nop();
    issue("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int cnt_stall;
    int cnt_busy;
    nop();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sel_a", bus.fwd_a_sel, 8'd0);
    check("reset_md_busy", bus.md_busy, 8'd0);
    rst_n = 1'b1;

    // Back-to-back RAW through EX/MEM
    issue("add r3", 1, 1, 2, 1, 1, 3, 0, 0, 0, 0); tick();
    issue("add r4", 3, 1, 3, 1, 1, 4, 0, 0, 0, 0);
    @(negedge clk); check("raw_stall", bus.stall, 8'd0); tick();
    nop();
    @(negedge clk); check("raw_sel_a", bus.fwd_a_sel, 8'd1); check("raw_sel_b", bus.fwd_b_sel, 8'd1);
    tick();

    // Load-use: one stall, bubble, then MEM/WB forward
    issue("lw r5", 1, 1, 0, 0, 1, 5, 1, 0, 0, 0); tick();
    issue("sub r6", 5, 1, 1, 1, 1, 6, 0, 0, 0, 0);
    @(negedge clk); check("lu_stall", bus.stall, 8'd1); tick();
    @(negedge clk); check("lu_stall_once", bus.stall, 8'd0); check("lu_bubble_sel_a", bus.fwd_a_sel, 8'd0);
    tick();
    nop();
    @(negedge clk); check("lu_sel_a", bus.fwd_a_sel, 8'd2); check("lu_sel_b", bus.fwd_b_sel, 8'd0);
    tick();

    // Nearest producer wins; r0 never forwards
    issue("add r7a", 1, 1, 2, 1, 1, 7, 0, 0, 0, 0); tick();
    issue("add r7b", 1, 1, 2, 1, 1, 7, 0, 0, 0, 0); tick();
    issue("or r8,r7,r0", 7, 1, 0, 1, 1, 8, 0, 0, 0, 0); tick();
    nop();
    @(negedge clk); check("near_sel_a", bus.fwd_a_sel, 8'd1); check("r0_sel_b", bus.fwd_b_sel, 8'd0);
    tick();
    issue("add r0", 1, 1, 2, 1, 1, 0, 0, 0, 0, 0); tick();
    issue("use r0", 0, 1, 0, 1, 1, 9, 0, 0, 0, 0); tick();
    nop();
    @(negedge clk); check("r0_sel_a", bus.fwd_a_sel, 8'd0); tick();

    // WB distance on A, MEM distance on B
    issue("add r12", 1, 1, 2, 1, 1, 12, 0, 0, 0, 0); tick();
    issue("add r13", 1, 1, 2, 1, 1, 13, 0, 0, 0, 0); tick();
    nop(); tick();
    issue("use r12,r13", 12, 1, 13, 1, 1, 16, 0, 0, 0, 0); tick();
    nop();
    @(negedge clk); check("wb_sel_a", bus.fwd_a_sel, 8'd3); check("mem_sel_b", bus.fwd_b_sel, 8'd2);
    tick();

    // Flush with load-use: stall wins; flush alone bubbles EX
    issue("lw r8", 1, 1, 0, 0, 1, 8, 1, 0, 0, 0); tick();
    issue("use r8 fl", 8, 1, 0, 0, 1, 14, 0, 0, 0, 1);
    @(negedge clk); check("flush_lu_stall", bus.stall, 8'd1); tick();
    issue("use r8", 8, 1, 0, 0, 1, 14, 0, 0, 0, 0);
    @(negedge clk); check("flush_lu_release", bus.stall, 8'd0); tick();
    issue("add r10 fl", 14, 1, 0, 0, 1, 10, 0, 0, 0, 1);
    @(negedge clk); check("flush_no_stall", bus.stall, 8'd0); tick();
    issue("use r10", 10, 1, 0, 0, 1, 11, 0, 0, 0, 0);
    @(negedge clk); check("flush_sel_bubble", bus.fwd_a_sel, 8'd0); tick();
    nop();
    @(negedge clk); check("flush_sel_a", bus.fwd_a_sel, 8'd0); tick();

    // Divide then mfhi: stall through BUSY
    issue("div", 1, 1, 2, 1, 0, 0, 0, 2, 0, 0); tick();
    issue("mfhi", 0, 0, 0, 0, 1, 15, 0, 0, 1, 0);
    cnt_stall = 0;
    cnt_busy  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.stall) break;
      cnt_stall++;
      if (bus.md_busy) cnt_busy++;
      @(posedge clk);
      #1;
    end
    check("div_stall_cycles", 8'(cnt_stall), 8'd10);
    check("div_busy_cycles", 8'(cnt_busy), 8'd10);
    check("div_done_busy", bus.md_busy, 8'd0);
    tick();
    nop(); tick();

    // Multiply latency and reserved opcode
    issue("mult", 1, 1, 2, 1, 0, 0, 0, 1, 0, 0); tick();
    nop();
    cnt_busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.md_busy) break;
      cnt_busy++;
      @(posedge clk);
      #1;
    end
    check("mult_busy_cycles", 8'(cnt_busy), 8'd5);
    tick();
    issue("md rsvd", 1, 1, 2, 1, 0, 0, 0, 3, 0, 0); tick();
    nop();
    @(negedge clk); check("rsvd_md_busy", bus.md_busy, 8'd0); tick();

    // Asynchronous reset during BUSY cycle 4
    issue("div2", 1, 1, 2, 1, 0, 0, 0, 2, 0, 0); tick();
    nop(); tick(); tick(); tick();
    issue("mfhi", 0, 0, 0, 0, 1, 15, 0, 0, 1, 0);
    #1;
    check("rst_pre_stall", bus.stall, 8'd1);
    check("rst_pre_busy", bus.md_busy, 8'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_busy", bus.md_busy, 8'd0);
    check("rst_async_stall", bus.stall, 8'd0);
    check("rst_async_sel_a", bus.fwd_a_sel, 8'd0);
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk); check("rst_mfhi_stall", bus.stall, 8'd0); check("rst_mfhi_busy", bus.md_busy, 8'd0);
    tick();
    nop();
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_sel_gen.md
FWD_SEL_GEN -- requirements
Module: fwd_sel_gen

Interface
REQ-001 Parameter MULT_LAT, default 5: EX-busy cycles for a multiply.
REQ-002 Parameter DIV_LAT, default 10: EX-busy cycles for a divide.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the ID instruction.
REQ-006 id_rs_used, id_rt_used  in  1 each  ID instruction reads rs / rt.
REQ-007 id_we, id_wa  in  1, 5  ID instruction writes register id_wa.
REQ-008 id_is_load  in  1  ID instruction is a load.
REQ-009 id_md_start  in  2  00 none, 01 multiply, 10 divide, 11 reserved (treated as none).
REQ-010 id_hilo_rd  in  1  ID instruction reads HI/LO.
REQ-011 flush  in  1  branch flush: ID instruction discarded.
REQ-012 fwd_a_sel, fwd_b_sel  out  2 each  registered operand-mux selects for EX: 0 regfile, 1 EX/MEM result, 2 MEM/WB result, 3 WB+1 latched result.
REQ-013 stall  out  1  hold PC and IF/ID this cycle.
REQ-014 md_busy  out  1  multiply/divide unit busy.

Function
REQ-015 Internal shadow registers SHALL track destination {valid, addr, is_load} for EX, MEM, WB and WB+1 stages, advancing one stage per clk.
REQ-016 Hazard match SHALL require shadow valid, addr equal to the source, addr != 0 and the source's *_used set.
REQ-017 Select computed in ID SHALL be (match in EX)?1 : (match in MEM)?2 : (match in WB)?3 : 0; nearest stage wins; select is registered and valid in EX exactly one cycle later.
REQ-018 Load-use: ID source matching an EX shadow with is_load SHALL assert stall combinationally for exactly one cycle.
REQ-019 On any stall cycle, the EX shadow SHALL load valid=0 and fwd_*_sel SHALL register 0 (bubble); ID-stage inputs are held by the upstream.
REQ-020 On flush without stall, the EX shadow SHALL load valid=0 and selects 0; stall takes precedence over flush.
REQ-021 MD FSM states IDLE, BUSY, DONE: IDLE->BUSY when the ID instruction is not stalled/flushed and id_md_start is 01/10, loading counter with MULT_LAT-1 / DIV_LAT-1; BUSY decrements to 0 then ->DONE; DONE->IDLE after one cycle, or ->BUSY if a new start is accepted that cycle.
REQ-022 md_busy SHALL be 1 in BUSY only; stall SHALL assert while md_busy and (id_hilo_rd or id_md_start != 00).
REQ-023 Counter width SHALL be clog2 of max(MULT_LAT, DIV_LAT); MULT_LAT, DIV_LAT >= 1 (latency 1 goes BUSY one cycle).
REQ-024 stall SHALL be the OR of load-use and MD stalls; no other output is combinational.

Reset
REQ-025 rst_n low SHALL immediately clear all shadow valid bits, selects to 0, MD FSM to IDLE, counter to 0; stall and md_busy therefore 0.
REQ-026 Reset assertion mid-BUSY SHALL abort the operation with no residual stall after release.

Structure
REQ-027 Select encodings (FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_WB1) and MD FSM state codes SHALL live in the shared CPU constants package.
REQ-028 MD FSM with counter SHALL be sub-module md_busy_fsm; forwarding/shadow logic stays in the top.

Verification
REQ-029 add r3 then add r4,r3,r3 back-to-back -> next cycle fwd_a_sel=1, fwd_b_sel=1, stall=0.
REQ-030 lw r5 then sub r6,r5,r1 -> stall=1 for one cycle, bubble, then fwd_a_sel=2, fwd_b_sel=0.
REQ-031 Writers to r7 in EX and MEM simultaneously, consumer reads r7 -> sel=1 (nearest wins); writer to r0 -> sel=0.
REQ-032 div with DIV_LAT=10, then mfhi next -> md_busy high 10 cycles, stall high until DONE, then stall=0.
REQ-033 rst_n low in BUSY cycle 4 -> outputs 0 asynchronously; after release, mfhi issues with stall=0.
REQ-034 flush with load-use stall same cycle -> stall=1 wins; flush alone -> EX bubble, selects 0.
